// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: byte bus between the memory controller and the memory/IO responder
// Signals: rdy (bus enable), ram_wr_i (1 = write), ram_addr_i (byte address),
//          ram_data_i (write data), ram_data_o (read data, one cycle after the address)
// Modports: master drives the request and reads ram_data_o; slave is the responder
interface mem_io_if #(parameter int ADDR_W = 32);
  logic              rdy;
  logic              ram_wr_i;
  logic [ADDR_W-1:0] ram_addr_i;
  logic [7:0]        ram_data_i;
  logic [7:0]        ram_data_o;
  modport master (output rdy, ram_wr_i, ram_addr_i, ram_data_i, input ram_data_o);
  modport slave (input rdy, ram_wr_i, ram_addr_i, ram_data_i, output ram_data_o);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus IO window (UART TX FIFO/serializer, RX FIFO, status, halt)
// Ports: clk, rst (async active-high), bus (mem_io_if.slave: rdy, ram_wr_i, ram_addr_i,
//        ram_data_i, ram_data_o), rx_valid_i/rx_data_i (incoming bytes), uart_tx_o (idle high),
//        halt_o (sticky halt flag)
// Define MEM_IO_TX_PARITY_EN to add an even-parity bit to each transmitted frame (8E1).
module mem_io_responder #(
  parameter int              ADDR_W       = 32,
  parameter int              RAM_AW       = 17,
  parameter logic [ADDR_W-1:0] IO_BASE    = 'h30000,
  parameter int              FIFO_AW      = 4,
  parameter int              CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  mem_io_if.slave    bus,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       uart_tx_o,
  output logic       halt_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef MEM_IO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t              st;
  logic [CW-1:0]       cnt;
  logic [2:0]          bitn;
  logic [7:0]          sh;
  logic                par;
  logic [7:0]          mem [2**RAM_AW];
  logic [7:0]          rx_mem [2**FIFO_AW];
  logic [7:0]          tx_mem [2**FIFO_AW];
  logic [FIFO_AW:0]    rx_wp, rx_rp, tx_wp, tx_rp;
  logic [7:0]          ram_q, io_q, io_rd;
  logic                sel_ram, rx_ovf;
  logic [ADDR_W-1:0]   off;
  logic                is_io, rd, wr, at0, at4, tick;
  logic                rx_empty, rx_full, rx_push, rx_pop;
  logic                tx_empty, tx_full, tx_push, tx_pop;
  assign is_io    = bus.ram_addr_i >= IO_BASE;
  assign off      = bus.ram_addr_i - IO_BASE;
  assign rd       = bus.rdy & ~bus.ram_wr_i;
  assign wr       = bus.rdy & bus.ram_wr_i;
  assign at0      = is_io & (off == '0);
  assign at4      = is_io & (off == ADDR_W'(4));
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = rx_wp == {~rx_rp[FIFO_AW], rx_rp[FIFO_AW-1:0]};
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = tx_wp == {~tx_rp[FIFO_AW], tx_rp[FIFO_AW-1:0]};
  assign tick     = cnt == CW'(CLKS_PER_BIT - 1);
  assign rx_pop   = rd & at0 & ~rx_empty;
  // a full FIFO still accepts a byte when a slot frees in the same cycle
  assign rx_push  = rx_valid_i & (~rx_full | rx_pop);
  assign tx_pop   = ~tx_empty & (st == IDLE | (st == STOP & tick));
  assign tx_push  = wr & at0 & (~tx_full | tx_pop);
  assign io_rd    = at0 ? (rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]]) :
                    at4 ? {5'b0, rx_ovf, ~rx_empty, tx_full} : 8'h00;
  // read data comes from whichever side the last sampled read targeted
  assign bus.ram_data_o = sel_ram ? ram_q : io_q;
  always_ff @(posedge clk) begin
    if (wr && !is_io) mem[bus.ram_addr_i[RAM_AW-1:0]] <= bus.ram_data_i;
    if (rd && !is_io) ram_q <= mem[bus.ram_addr_i[RAM_AW-1:0]];
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data_i;
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.ram_data_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_ovf  <= 1'b0;
      sel_ram <= 1'b0;
      io_q    <= 8'h00;
      halt_o  <= 1'b0;
    end else begin
      rx_wp  <= rx_wp + (FIFO_AW+1)'(rx_push);
      rx_rp  <= rx_rp + (FIFO_AW+1)'(rx_pop);
      // a drop in the same cycle as a status read keeps the flag set
      rx_ovf <= (rx_valid_i & rx_full & ~rx_pop) | (rx_ovf & ~(rd & at4));
      halt_o <= halt_o | (wr & at4);
      if (rd) begin
        sel_ram <= ~is_io;
        if (is_io) io_q <= io_rd;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      par       <= 1'b0;
      uart_tx_o <= 1'b1;
      tx_wp     <= '0;
      tx_rp     <= '0;
    end else begin
      tx_wp <= tx_wp + (FIFO_AW+1)'(tx_push);
      tx_rp <= tx_rp + (FIFO_AW+1)'(tx_pop);
      cnt   <= (st == IDLE || tick) ? '0 : cnt + 1'b1;
      // loading from IDLE or from the last STOP cycle gives gap-free back-to-back frames
      if (tx_pop) begin
        st        <= START;
        sh        <= tx_mem[tx_rp[FIFO_AW-1:0]];
        par       <= ^tx_mem[tx_rp[FIFO_AW-1:0]];
        uart_tx_o <= 1'b0;
      end else if (tick) begin
        case (st)
          START: begin
            st        <= DATA;
            bitn      <= '0;
            uart_tx_o <= sh[0];
          end
          DATA: begin
            if (bitn == 3'd7) begin
`ifdef MEM_IO_TX_PARITY_EN
              st        <= PARITY;
              uart_tx_o <= par;
`else
              st        <= STOP;
              uart_tx_o <= 1'b1;
`endif
            end else begin
              bitn      <= bitn + 1'b1;
              sh        <= sh >> 1;
              uart_tx_o <= sh[1];
            end
          end
`ifdef MEM_IO_TX_PARITY_EN
          PARITY: begin
            st        <= STOP;
            uart_tx_o <= 1'b1;
          end
`endif
          STOP: begin
            st        <= IDLE;
            uart_tx_o <= 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
`ifndef MEM_IO_TX_PARITY_EN
  logic unused_par;
  assign unused_par = par;
`endif
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: self-checking bench for mem_io_responder (CLKS_PER_BIT = 4)
module tb_mem_io_responder;
`ifdef MEM_IO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CPB = 4;
  localparam int FB  = 10 + PAR;
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  e;
  } vec_t;
  logic       clk = 0;
  logic       rst = 0;
  logic       rx_valid_i = 0;
  logic [7:0] rx_data_i = 0;
  logic       uart_tx_o, halt_o;
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] last = 0;
  logic [7:0] sb[$];
  vec_t       tbl [10];
  mem_io_if #(.ADDR_W(32)) bif();
  mem_io_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .bus(bif), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .uart_tx_o(uart_tx_o), .halt_o(halt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bus(input bit r, input bit w, input logic [31:0] a, input logic [7:0] d,
                     input logic [7:0] e, input string nm);
    bif.rdy = r;
    bif.ram_wr_i = w;
    bif.ram_addr_i = a;
    bif.ram_data_i = d;
    if (r && !w) last = e;
    sb.push_back(last);
    @(posedge clk); #1;
    bif.rdy = 0;
    chk(nm, bif.ram_data_o, sb.pop_front());
  endtask
  task automatic rx_push(input logic [7:0] d);
    rx_valid_i = 1;
    rx_data_i = d;
    @(posedge clk); #1;
    rx_valid_i = 0;
  endtask
  function automatic logic fbit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (PAR == 1 && i == 9) ? ^b : 1'b1;
  endfunction
  task automatic rx_frame(output logic [7:0] b, output bit ok);
    int t = 0;
    b = 0;
    while (uart_tx_o !== 1'b0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    ok = uart_tx_o === 1'b0;
    if (ok) begin
      repeat (CPB/2) @(posedge clk);
      #1;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(posedge clk);
        #1;
        b[j] = uart_tx_o;
      end
      repeat (CPB * (FB - 9)) @(posedge clk);
      #1;
      ok = uart_tx_o === 1'b1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b;
    bit         ok;
    bit         low;
    tbl = '{
      '{1, 32'h00010, 8'hA5, 8'h00},
      '{0, 32'h00010, 8'h00, 8'hA5},
      '{0, 32'h20010, 8'h00, 8'hA5},
      '{1, 32'h01234, 8'h5A, 8'h00},
      '{0, 32'h01234, 8'h00, 8'h5A},
      '{1, 32'h0FFFF, 8'h3C, 8'h00},
      '{0, 32'h2FFFF, 8'h00, 8'h3C},
      '{0, 32'h30008, 8'h00, 8'h00},
      '{0, 32'h30004, 8'h00, 8'h00},
      '{0, 32'h00010, 8'h00, 8'hA5}
    };
    bif.rdy = 0;
    bif.ram_wr_i = 0;
    bif.ram_addr_i = 0;
    bif.ram_data_i = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", bif.ram_data_o, 8'h00);
    chk("rst_uart", uart_tx_o, 1'b1);
    chk("rst_halt", halt_o, 1'b0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      bus(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
    rx_push(8'h33);
    rx_push(8'h44);
    bus(1, 0, 32'h30004, 0, 8'h02, "rx_stat_pre");
    bus(1, 0, 32'h30000, 0, 8'h33, "rx_pop0");
    bus(1, 0, 32'h30000, 0, 8'h44, "rx_pop1");
    bus(1, 0, 32'h30000, 0, 8'h00, "rx_pop_empty");
    bus(1, 0, 32'h30004, 0, 8'h00, "rx_stat_post");
    for (int i = 0; i < 17; i++) rx_push(8'h10 + 8'(i));
    bus(1, 0, 32'h30004, 0, 8'h06, "ovf_stat");
    bus(1, 0, 32'h30004, 0, 8'h02, "ovf_clr");
    for (int i = 0; i < 16; i++) bus(1, 0, 32'h30000, 0, 8'h10 + 8'(i), $sformatf("ovf_pop%0d", i));
    bus(1, 0, 32'h30004, 0, 8'h00, "ovf_drained");
    fork
      bus(1, 1, 32'h30000, 8'h41, 0, "tx_wr");
      begin
        @(posedge clk); #1;
        for (int k = 0; k < CPB * FB; k++) begin
          @(posedge clk); #1;
          chk($sformatf("tx41_%0d", k), uart_tx_o, fbit(8'h41, k / CPB));
        end
      end
    join
    @(posedge clk); #1;
    fork
      begin
        bus(1, 1, 32'h30000, 8'h41, 0, "b2b_wr0");
        bus(1, 1, 32'h30000, 8'hC3, 0, "b2b_wr1");
      end
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 2 * CPB * FB; k++) begin
          @(posedge clk); #1;
          chk($sformatf("b2b_%0d", k), uart_tx_o,
              fbit(k < CPB * FB ? 8'h41 : 8'hC3, (k / CPB) % FB));
        end
      end
    join
    @(posedge clk); #1;
    chk("b2b_idle", uart_tx_o, 1'b1);
    fork
      begin
        bus(1, 1, 32'h30000, 8'h5A, 0, "full_wr_first");
        for (int i = 0; i < 17; i++) bus(1, 1, 32'h30000, 8'h80 + 8'(i), 0, $sformatf("full_wr%0d", i));
        bus(1, 0, 32'h30004, 0, 8'h01, "tx_full_stat");
      end
      begin
        for (int f = 0; f < 17; f++) begin
          rx_frame(b, ok);
          chk($sformatf("full_frame_ok%0d", f), 8'(ok), 8'h01);
          chk($sformatf("full_frame%0d", f), b, f == 0 ? 8'h5A : 8'h80 + 8'(f - 1));
        end
        low = 0;
        repeat (60) begin
          @(posedge clk); #1;
          if (uart_tx_o !== 1'b1) low = 1;
        end
        chk("tx_17th_dropped", 8'(low), 8'h00);
      end
    join
    bus(1, 0, 32'h30004, 0, 8'h00, "tx_stat_empty");
    bus(0, 1, 32'h30004, 0, 0, "halt_rdy0");
    chk("halt_rdy0_flag", halt_o, 1'b0);
    bus(0, 1, 32'h00010, 8'h77, 0, "ram_wr_rdy0");
    bus(0, 0, 32'h01234, 0, 0, "ram_rd_rdy0");
    bus(1, 0, 32'h00010, 0, 8'hA5, "ram_rdy0_kept");
    bus(1, 1, 32'h30004, 0, 0, "halt_wr");
    chk("halt_set", halt_o, 1'b1);
    bus(1, 1, 32'h30000, 8'h00, 0, "rst_wr0");
    bus(1, 1, 32'h30000, 8'h11, 0, "rst_wr1");
    bus(1, 1, 32'h30000, 8'h22, 0, "rst_wr2");
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_uart_low", uart_tx_o, 1'b0);
    rst = 1;
    #1;
    chk("midrst_uart", uart_tx_o, 1'b1);
    chk("midrst_halt", halt_o, 1'b0);
    chk("midrst_data", bif.ram_data_o, 8'h00);
    last = 0;
    @(posedge clk); #1;
    rst = 0;
    low = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (uart_tx_o !== 1'b1) low = 1;
    end
    chk("rst_frame_abandoned", 8'(low), 8'h00);
    bus(1, 0, 32'h30004, 0, 8'h00, "rst_stat");
    bus(1, 0, 32'h00010, 0, 8'hA5, "ram_survives_rst");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Byte-wide memory/IO responder on the far side of the CPU memory controller's RAM bus.
- Serves the controller's `ram_wr` / `ram_addr` / `ram_data` byte transactions.
- Contains a synchronous RAM array and a small IO window: a UART transmitter with TX FIFO, an RX byte FIFO, a status register and a halt latch.
- Sits at the top level between the memory controller and the board pins / testbench.

Parameters:
- ADDR_W, 32, width of bus address.
- RAM_AW, 17, RAM index width; RAM holds 2^RAM_AW bytes.
- IO_BASE, 32'h30000, first IO address; addresses below it map to RAM.
- FIFO_AW, 4, log2 depth of TX and RX FIFOs (16 entries each).
- CLKS_PER_BIT, 8, clk cycles per UART bit; legal minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  bus enable; when 0, bus side is frozen.
- ram_wr_i  in  1  1 = write byte, 0 = read byte.
- ram_addr_i  in  ADDR_W  byte address.
- ram_data_i  in  8  write data.
- ram_data_o  out  8  read data, one cycle after address.
- rx_valid_i  in  1  incoming byte strobe.
- rx_data_i  in  8  incoming byte.
- uart_tx_o  out  1  serial output, idle high.
- halt_o  out  1  sticky program-halt flag.

Behaviour:
- Reset values: ram_data_o=0, uart_tx_o=1, halt_o=0, both FIFOs empty, serializer IDLE, overflow flag 0. RAM contents are not reset.
- Decode:
  - addr < IO_BASE: RAM at index addr[RAM_AW-1:0]; higher bits alias.
  - addr >= IO_BASE: IO, offset = addr - IO_BASE.
- Bus cycle (rdy=1):
  - Address/data sampled at posedge N. Read result is registered onto ram_data_o at posedge N and held until the next sampled read.
  - Fixed 1-cycle latency for both RAM and IO.
  - Write cycles leave ram_data_o unchanged.
- rdy=0: no RAM write, no FIFO push/pop from the bus, no halt set, ram_data_o holds. The UART serializer and rx_valid_i capture keep running.
- IO map, reads:
  - +0: pops RX FIFO and returns the byte; returns 0 with no pop if empty.
  - +4: status {5'b0, rx_ovf, rx_nonempty, tx_full}.
  - Others: 0.
- IO map, writes:
  - +0: pushes into TX FIFO; silently dropped if full.
  - +4: sets halt_o=1 (sticky until reset).
  - Others: ignored.
- Every sampled read of +0 is a pop. The master must present that address exactly once per byte.
- RX FIFO:
  - rx_valid_i pushes rx_data_i.
  - If full with no same-cycle pop: byte dropped, rx_ovf set sticky. rx_ovf clears on a read of +4.
  - Full plus simultaneous pop and push: both succeed, count unchanged.
- TX FIFO + serializer, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop the head byte, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE and re-check the FIFO the same cycle.
  - Back-to-back bytes therefore have no idle gap.
  - Push to a full FIFO in the same cycle as a serializer pop is accepted.
- FIFO pointers are FIFO_AW+1 bits; full when MSBs differ and the rest are equal. Wrap-around is natural.
- Reset mid-frame: uart_tx_o returns to 1 immediately; the frame is abandoned and both FIFOs are emptied.

Optional Feature:
- Macro MEM_IO_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, driving even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame is 11 bits.
- Undefined: plain 8N1, 10-bit frame, PARITY state absent.

Test Plan:
- RAM: write 8'hA5 to 0x00010, then read 0x00010 next cycle -> ram_data_o=8'hA5 one cycle after the read address; read of 0x20010 (alias) also returns 8'hA5.
- TX (CLKS_PER_BIT=4): write 8'h41 to 0x30000 -> uart_tx_o low 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles. Two writes give back-to-back frames of 40 cycles each.
- TX full: 17 writes with the serializer stalled in frame -> tx_full=1 via read of 0x30004 (status 8'h01); 17th byte never transmitted.
- RX: rx_valid_i with 8'h33 then 8'h44; reads of 0x30000 return 8'h33, 8'h44, then 8'h00; status reads 8'h02 before the pops, 8'h00 after.
- Overflow: 17 rx pushes -> status 8'h06; second status read -> 8'h02.
- Halt/rdy: write to 0x30004 with rdy=0 -> halt_o stays 0; repeat with rdy=1 -> halt_o=1 next cycle; assert rst mid-frame -> uart_tx_o=1, halt_o=0 immediately.
